// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU address decode to RAM / UART / cycle counter, with TX FIFO and drain-to-halt FSM.
// Optional cycle counter and snapshot: define BRIDGE_CYCLE_COUNTER_EN.
module mem_io_bridge #(
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halted
);
  localparam int PW = $clog2(TX_FIFO_DEPTH);

  typedef enum logic [2:0] {SEL_ZERO, SEL_RAM, SEL_RX, SEL_CNT0, SEL_CNT1, SEL_CNT2, SEL_CNT3} sel_t;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  logic        io_sel;
  logic [15:0] io_off;
  logic        unused_hi_addr;
  sel_t        sel_q, sel_next;
  state_t      state;
  logic        zero_done;
  logic [7:0]  rx_q;

  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_next;
  logic        fifo_full, cpu_push_req, drain_push_req, push, pop;
  logic [7:0]  push_data;

  assign io_sel         = (cpu_a[17:16] == 2'b11);
  assign io_off         = cpu_a[15:0];
  assign unused_hi_addr = ^cpu_a[31:18];

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = cpu_wr & rdy_in & ~io_sel;
  assign rx_pop   = rdy_in & ~rst_in & ~cpu_wr & io_sel & (io_off == 16'h0000) & rx_valid;

  always_comb begin
    sel_next = SEL_ZERO;
    if (!cpu_wr) begin
      if (!io_sel) begin
        sel_next = SEL_RAM;
      end else begin
        case (io_off)
          16'h0000: sel_next = rx_valid ? SEL_RX : SEL_ZERO;
`ifdef BRIDGE_CYCLE_COUNTER_EN
          16'h0004: sel_next = SEL_CNT0;
          16'h0005: sel_next = SEL_CNT1;
          16'h0006: sel_next = SEL_CNT2;
          16'h0007: sel_next = SEL_CNT3;
`endif
          default:  sel_next = SEL_ZERO;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_q <= SEL_ZERO;
      rx_q  <= 8'h00;
    end else if (rdy_in) begin
      sel_q <= sel_next;
      if (rx_pop) rx_q <= rx_data;
    end
  end

`ifdef BRIDGE_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt, snap;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cycle_cnt <= 32'd0;
      snap      <= 32'd0;
    end else if (rdy_in) begin
      if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
      if (!cpu_wr && io_sel && io_off == 16'h0004) snap <= cycle_cnt;
    end
  end
`endif

  always_comb begin
    cpu_din = 8'h00;
    case (sel_q)
      SEL_RAM:  cpu_din = ram_din;
      SEL_RX:   cpu_din = rx_q;
`ifdef BRIDGE_CYCLE_COUNTER_EN
      SEL_CNT0: cpu_din = snap[7:0];
      SEL_CNT1: cpu_din = snap[15:8];
      SEL_CNT2: cpu_din = snap[23:16];
      SEL_CNT3: cpu_din = snap[31:24];
`endif
      default:  cpu_din = 8'h00;
    endcase
  end

  // CPU pushes only in RUN; the drain terminator is pushed by the FSM, never both at once.
  assign fifo_full      = (count == (PW+1)'(TX_FIFO_DEPTH));
  assign cpu_push_req   = rdy_in & cpu_wr & io_sel & (io_off == 16'h0000) & (cpu_dout != 8'h00) & (state == ST_RUN);
  assign drain_push_req = rdy_in & (state == ST_DRAIN) & ~zero_done;
  assign push           = (cpu_push_req | drain_push_req) & ~fifo_full;
  assign push_data      = drain_push_req ? 8'h00 : cpu_dout;
  assign tx_valid       = (count != '0);
  assign pop            = rdy_in & tx_valid & tx_ready;
  assign tx_data        = fifo_mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count          <= count_next;
      io_buffer_full <= (count_next >= (PW+1)'(TX_FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_RUN;
      zero_done <= 1'b0;
      halted    <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        ST_RUN: begin
          if (cpu_wr && io_sel && io_off == 16'h0004) begin
            state     <= ST_DRAIN;
            zero_done <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!zero_done) begin
            if (!fifo_full) zero_done <= 1'b1;
          end else if (count == '0) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - Self-checking bench for mem_io_bridge: vector table plus TX scoreboard.
module tb_mem_io_bridge;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_wr, io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_dout, ram_din;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_pop, halted;

  mem_io_bridge #(.TX_FIFO_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .halted(halted)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram_mem [0:131071];
  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  int         n_cmp, n_fail, live;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
`ifdef BRIDGE_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every accepted TX byte must match the oldest expected byte.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && tx_valid && tx_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h expected none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    if (rdy_in) live++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    exp_q.delete();
    cpu_a = 32'h0003_0000; cpu_wr = 1'b0; cpu_dout = 8'h00; rx_valid = 1'b1; rx_data = 8'hEE;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_full", io_buffer_full, 0);
    check("rst_halted", halted, 0);
    check("rst_cpu_din", cpu_din, 0);
    check("rst_rx_pop", rx_pop, 0);
    cpu_a = 32'h0; rx_valid = 1'b0; rx_data = 8'h00;
    rst_in = 1'b0;
    live = 0;
  endtask

  task automatic cpu_write(input logic [17:0] addr, input logic [7:0] data);
    cpu_a = {14'h0, addr}; cpu_dout = data; cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0; cpu_a = 32'h0; cpu_dout = 8'h00;
  endtask

  task automatic cpu_read(input logic [17:0] addr, output logic [7:0] data);
    cpu_a = {14'h0, addr}; cpu_wr = 1'b0;
    step();
    data = cpu_din;
    cpu_a = 32'h0;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_valid) && k < 200) begin
      step();
      k++;
    end
    check(name, (k < 200), 1);
  endtask

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [7:0]  data;
    logic        rxv;
    logic [7:0]  rxd;
    logic        chk_din;
    logic [7:0]  exp_din;
    logic        exp_we;
    logic        exp_pop;
  } vec_t;

  vec_t       vecs [14];
  logic [7:0] d;
  logic [31:0] snap_exp;

  initial begin
    n_cmp = 0; n_fail = 0; live = 0;
    rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cpu_a = 32'h0; cpu_dout = 8'h00; cpu_wr = 1'b0; rst_in = 1'b1;
    do_reset();

    //            wr    addr       data   rxv   rxd    chk   din    we    pop
    vecs[0]  = '{1'b1, 18'h00100, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 18'h00100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 18'h1FFFF, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 18'h1FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 18'h2FFFF, 8'h9E, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 18'h2FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h9E, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 18'h30000, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 18'h30000, 8'h00, 1'b0, 8'hEE, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 18'h30010, 8'h00, 1'b1, 8'h44, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 18'h30001, 8'h12, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 18'h30008, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 18'h00100, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 18'h30000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 18'h30003, 8'h00, 1'b1, 8'h66, 1'b1, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      cpu_a = {14'h0, vecs[i].addr}; cpu_wr = vecs[i].wr; cpu_dout = vecs[i].data;
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      #1;
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("vec%0d_rx_pop", i), rx_pop, vecs[i].exp_pop);
      step();
      if (vecs[i].chk_din) check($sformatf("vec%0d_cpu_din", i), cpu_din, vecs[i].exp_din);
    end
    cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00; rx_valid = 1'b0;

    // Zero byte is filtered out of the TX stream.
    tx_ready = 1'b1;
    exp_q.push_back(8'h41); cpu_write(18'h30000, 8'h41);
    cpu_write(18'h30000, 8'h00);
    exp_q.push_back(8'h42); cpu_write(18'h30000, 8'h42);
    wait_empty("stream_drained");

    // Fill to full with tx stalled; the ninth push must be dropped.
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      cpu_write(18'h30000, 8'(i));
      if (i == 6) check("full_after_6", io_buffer_full, 0);
      if (i == 7) check("full_after_7", io_buffer_full, 1);
    end
    check("full_after_8", io_buffer_full, 1);
    cpu_write(18'h30000, 8'h99);
    check("full_after_drop", io_buffer_full, 1);
    check("head_after_drop", tx_data, 8'h01);
    tx_ready = 1'b1;
    wait_empty("full_drained");
    check("full_cleared", io_buffer_full, 0);

    // Counter snapshot after a fixed number of cycles.
    do_reset();
    repeat (100) step();
    snap_exp = 32'(live);
    cpu_read(18'h30004, d);
    check("cnt_byte0", d, CNT_EN ? {24'h0, snap_exp[7:0]} : 32'h0);
    cpu_read(18'h30005, d);
    check("cnt_byte1", d, CNT_EN ? {24'h0, snap_exp[15:8]} : 32'h0);
    cpu_read(18'h30006, d);
    check("cnt_byte2", d, CNT_EN ? {24'h0, snap_exp[23:16]} : 32'h0);
    cpu_read(18'h30007, d);
    check("cnt_byte3", d, CNT_EN ? {24'h0, snap_exp[31:24]} : 32'h0);

    // rdy_in low freezes pops, counter and read data.
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back(8'hA1); cpu_write(18'h30000, 8'hA1);
    exp_q.push_back(8'hA2); cpu_write(18'h30000, 8'hA2);
    exp_q.push_back(8'hA3); cpu_write(18'h30000, 8'hA3);
    cpu_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'hC3;
    step();
    check("frz_rx_read", cpu_din, 8'hC3);
    rx_data = 8'h11; rdy_in = 1'b0; tx_ready = 1'b1;
    #1;
    check("frz_rx_pop", rx_pop, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("frz%0d_cpu_din", i), cpu_din, 8'hC3);
      check($sformatf("frz%0d_tx_data", i), tx_data, 8'hA1);
    end
    rdy_in = 1'b1; cpu_a = 32'h0; rx_valid = 1'b0;
    wait_empty("frz_drained");
    snap_exp = 32'(live);
    cpu_read(18'h30004, d);
    check("frz_cnt_byte0", d, CNT_EN ? {24'h0, snap_exp[7:0]} : 32'h0);

    // Drain to halt: three data bytes, terminator, then halt.
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back(8'h11); cpu_write(18'h30000, 8'h11);
    exp_q.push_back(8'h22); cpu_write(18'h30000, 8'h22);
    exp_q.push_back(8'h33); cpu_write(18'h30000, 8'h33);
    cpu_write(18'h30004, 8'hFF);
    exp_q.push_back(8'h00);
    step();
    cpu_write(18'h30000, 8'h55);
    check("drain_not_halted", halted, 0);
    tx_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (tx_valid && k < 100) begin
        step();
        k++;
      end
      check("drain_empty_bound", (k < 100), 1);
    end
    check("halt_at_empty", halted, 0);
    step();
    check("halt_next_cycle", halted, 1);
    check("drain_all_sent", exp_q.size(), 0);
    cpu_write(18'h30000, 8'h66);
    repeat (3) step();
    check("halt_write_ignored", tx_valid, 0);
    cpu_write(18'h00200, 8'h5C);
    cpu_read(18'h00200, d);
    check("halt_ram_ok", d, 8'h5C);

    // Reset in the middle of a drain discards the queued bytes.
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back(8'hB1); cpu_write(18'h30000, 8'hB1);
    exp_q.push_back(8'hB2); cpu_write(18'h30000, 8'hB2);
    cpu_write(18'h30004, 8'h01);
    step();
    do_reset();
    tx_ready = 1'b1;
    exp_q.push_back(8'h77); cpu_write(18'h30000, 8'h77);
    wait_empty("post_rst_drained");
    check("post_rst_halted", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
